ext_pipe: RTL and testbench
===========================

EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 The module SHALL have parameter IN_W, default 16, immediate width.
REQ-002 The module SHALL have parameter OUT_W, default 32, result width; legal only if OUT_W >= 2*IN_W and OUT_W is a multiple of 16.
REQ-003 The module SHALL have parameter TAG_W, default 5, width of the sideband tag (destination register number).
REQ-004 Derived OFF_W = log2(OUT_W/8), the byte-offset width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block can accept a request this cycle.
REQ-009 in_op  input  3  extension mode.
REQ-010 in_imm  input  IN_W  immediate operand.
REQ-011 in_word  input  OUT_W  memory read word for load modes.
REQ-012 in_off  input  OFF_W  byte offset within in_word.
REQ-013 in_tag  input  TAG_W  sideband, returned unchanged.
REQ-014 out_valid  output  1  result present.
REQ-015 out_ready  input  1  consumer takes result this cycle.
REQ-016 out_data / out_tag / out_err  output  OUT_W / TAG_W / 1  result, tag, misalignment flag.
REQ-017 err_cnt  output  8  count of accepted misaligned requests.

Function
REQ-018 Modes: 000 zero-extend in_imm; 001 in_imm in the top IN_W bits with lower bits zero; 010 sign-extend in_imm; 011 LB sign-extend byte at in_off; 100 LBU zero-extend that byte; 101 LH sign-extend halfword at in_off; 110 LHU zero-extend that halfword; 111 pass in_word through.
REQ-019 Byte n of in_word SHALL be bits [8n+7:8n] (little-endian); halfword at in_off SHALL be bits [8*in_off+15 : 8*in_off].
REQ-020 Modes 101/110 with in_off[0]=1 SHALL produce out_data=0, out_err=1; every other case SHALL produce out_err=0.
REQ-021 in_off SHALL be ignored for modes 000, 001, 010, 111.
REQ-022 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-023 Storage SHALL be an output register plus one skid register; state EMPTY (0 held), ONE (output register valid), TWO (both valid).
REQ-024 in_ready SHALL equal (state != TWO) && !reset, with no combinational path from out_ready or in_valid.
REQ-025 Transitions: EMPTY+in -> ONE; ONE+in, no out -> TWO (new item to skid); ONE+out, no in -> EMPTY; ONE+in+out -> ONE (new item to output register); TWO+out -> ONE (skid moves to output register); otherwise hold.
REQ-026 Latency SHALL be one cycle: an item accepted in EMPTY appears on out_valid the next cycle.
REQ-027 Throughput SHALL be one item per cycle while out_ready is held high.
REQ-028 Results SHALL leave in acceptance order; none dropped or duplicated.
REQ-029 out_data, out_tag, out_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-030 Extension SHALL be computed at acceptance; stored items SHALL be unaffected by later input changes.
REQ-031 err_cnt SHALL increment by 1 on each accepted request with out_err=1, saturating at 255.

Reset
REQ-032 While reset is high at a clock edge: state SHALL become EMPTY, out_valid=0, out_data=0, out_tag=0, out_err=0, err_cnt=0, and no request SHALL be accepted.
REQ-033 Reset asserted mid-operation SHALL discard all buffered items; in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-034 IN_W=16, OUT_W=32, in_imm=16'h8001, modes 000/001/010 -> out_data 32'h00008001 / 32'h80010000 / 32'hFFFF8001, one cycle after accept.
REQ-035 in_word=32'h80FF7F01, LB at off 0..3 -> 32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80; LBU off 3 -> 32'h00000080; LH off 2 -> 32'hFFFF80FF; LHU off 2 -> 32'h000080FF.
REQ-036 LH off 1, tag 5'd7 -> out_data 0, out_err 1, out_tag 7; 300 such accepts -> err_cnt 255.
REQ-037 Stream 4 tagged items with out_ready=0: 2 accepted, then in_ready=0; raise out_ready -> tags 1,2,3,4 in order, no loss.
REQ-038 Random in_valid/out_ready, 10k items vs reference model -> exact in-order match; out_data stable while stalled.
REQ-039 Reset asserted in state TWO -> next cycle out_valid=0, err_cnt=0; one cycle after deassert in_ready=1, and the first new item appears one cycle after acceptance.

Source files
------------

// File: rtl/ext_pipe.sv
// Immediate/load-data extension unit with a two-entry output buffer.
// 1-cycle latency; a skid register absorbs one item so in_ready never depends on out_ready.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5,
  localparam int OFF_W = $clog2(OUT_W / 8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [OUT_W-1:0] in_word,
  input  logic [OFF_W-1:0] in_off,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, state_n;

  logic             accept, take;
  logic             load_out, load_skid, skid_to_out;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [OUT_W-1:0] res_data;
  logic             res_err;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;

  assign in_ready  = (state != TWO) && !reset;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  // Little-endian byte/halfword select; odd halfword offsets are flagged below.
  always_comb begin
    sel_byte = 8'h00;
    sel_half = 16'h0000;
    for (int n = 0; n < OUT_W / 8; n++) begin
      if (in_off == OFF_W'(n)) sel_byte = in_word[8*n +: 8];
    end
    for (int n = 0; n < OUT_W / 8 - 1; n++) begin
      if (in_off == OFF_W'(n)) sel_half = in_word[8*n +: 16];
    end
  end

  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (in_op)
      3'b000: res_data = {{(OUT_W-IN_W){1'b0}}, in_imm};
      3'b001: res_data = {in_imm, {(OUT_W-IN_W){1'b0}}};
      3'b010: res_data = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
      3'b011: res_data = {{(OUT_W-8){sel_byte[7]}}, sel_byte};
      3'b100: res_data = {{(OUT_W-8){1'b0}}, sel_byte};
      3'b101: begin
        if (in_off[0]) res_err = 1'b1;
        else           res_data = {{(OUT_W-16){sel_half[15]}}, sel_half};
      end
      3'b110: begin
        if (in_off[0]) res_err = 1'b1;
        else           res_data = {{(OUT_W-16){1'b0}}, sel_half};
      end
      default: res_data = in_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_n  = ONE;
          load_out = 1'b1;
        end
      end
      ONE: begin
        if (accept && take) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_n   = TWO;
          load_skid = 1'b1;
        end else if (take) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (take) begin
          state_n     = ONE;
          skid_to_out = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_tag  <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_out) begin
        out_data <= res_data;
        out_tag  <= in_tag;
        out_err  <= res_err;
      end else if (skid_to_out) begin
        out_data <= skid_data;
        out_tag  <= skid_tag;
        out_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= res_data;
        skid_tag  <= in_tag;
        skid_err  <= res_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                       err_cnt <= 8'd0;
    else if (accept && res_err && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe at default widths.
module tb_ext_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  t;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [15:0] in_imm = '0;
  logic [31:0] in_word = '0;
  logic [1:0]  in_off = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int out_count = 0;
  int acc_count = 0;
  int exp_cnt = 0;
  exp_t sb[$];
  bit   prev_stall = 0;
  exp_t prev_out;

  ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .in_word(in_word), .in_off(in_off), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] imm,
                                 input logic [31:0] word, input logic [1:0] off,
                                 input logic [4:0] tag);
    exp_t r;
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      default: b = word[31:24];
    endcase
    h = (off == 2'd2) ? word[31:16] : word[15:0];
    r.t = tag;
    r.e = 1'b0;
    r.d = 32'h0;
    case (op)
      3'd0: r.d = {16'h0, imm};
      3'd1: r.d = {imm, 16'h0};
      3'd2: r.d = {{16{imm[15]}}, imm};
      3'd3: r.d = {{24{b[7]}}, b};
      3'd4: r.d = {24'h0, b};
      3'd5: if (off[0]) r.e = 1'b1; else r.d = {{16{h[15]}}, h};
      3'd6: if (off[0]) r.e = 1'b1; else r.d = {16'h0, h};
      default: r.d = word;
    endcase
    return r;
  endfunction

  // Scoreboard, err_cnt model and stall-stability monitor.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      exp_cnt = 0;
      prev_stall = 0;
    end else begin
      checks++;
      if (err_cnt !== exp_cnt[7:0]) begin
        errors++;
        $display("FAIL err_cnt_track: got %0d expected %0d", err_cnt, exp_cnt);
      end
      if (prev_stall) begin
        checks++;
        if ({out_data, out_tag, out_err} !== prev_out) begin
          errors++;
          $display("FAIL stall_stable: got %h expected %h", {out_data, out_tag, out_err}, prev_out);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        out_count++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got tag %0d expected no output", out_tag);
        end else begin
          e = sb.pop_front();
          if ({out_data, out_tag, out_err} !== e) begin
            errors++;
            $display("FAIL sb_compare: got d=%h t=%0d e=%b expected d=%h t=%0d e=%b",
                     out_data, out_tag, out_err, e.d, e.t, e.e);
          end
        end
      end
      if (in_valid && in_ready) begin
        acc_count++;
        e = model(in_op, in_imm, in_word, in_off, in_tag);
        sb.push_back(e);
        if (e.e && exp_cnt < 255) exp_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_data, out_tag, out_err};
    end
  end

  task automatic send(input logic [2:0] op, input logic [15:0] imm, input logic [31:0] word,
                      input logic [1:0] off, input logic [4:0] tag);
    bit done = 0;
    in_op = op; in_imm = imm; in_word = word; in_off = off; in_tag = tag;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_tag, out_err, err_cnt, in_ready} !== 48'h0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h t=%0d e=%b cnt=%0d rdy=%b expected all zero",
               out_valid, out_data, out_tag, out_err, err_cnt, in_ready);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_imm_modes();
    logic [31:0] exp_d[3];
    exp_d[0] = 32'h00008001; exp_d[1] = 32'h80010000; exp_d[2] = 32'hFFFF8001;
    out_ready = 1'b1;
    for (int m = 0; m < 3; m++) begin
      send(3'(m), 16'h8001, 32'hDEADBEEF, 2'd3, 5'(m));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[m] || out_err !== 1'b0) begin
        errors++;
        $display("FAIL imm_mode%0d: got v=%b d=%h expected v=1 d=%h", m, out_valid, out_data, exp_d[m]);
      end
    end
  endtask

  task automatic test_loads();
    logic [2:0]  ops[7];
    logic [1:0]  offs[7];
    logic [31:0] exps[7];
    ops  = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6};
    offs = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
    exps = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
             32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(ops[i], 16'h1234, 32'h80FF7F01, offs[i], 5'(i + 8));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exps[i] || out_err !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d: got v=%b d=%h e=%b expected v=1 d=%h e=0",
                 i, out_valid, out_data, out_err, exps[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    out_ready = 1'b1;
    send(3'd5, 16'h0, 32'h80FF7F01, 2'd1, 5'd7);
    @(negedge clk);
    checks++;
    if (out_data !== 32'h0 || out_err !== 1'b1 || out_tag !== 5'd7 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL misaligned: got d=%h e=%b t=%0d cnt=%0d expected d=0 e=1 t=7 cnt=1",
               out_data, out_err, out_tag, err_cnt);
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (299) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL err_saturate: got %0d expected 255", err_cnt);
    end
  endtask

  task automatic test_backpressure();
    int base_acc, base_out;
    do_reset();
    out_ready = 1'b0;
    base_acc = acc_count;
    base_out = out_count;
    in_op = 3'd0; in_imm = 16'h0011; in_word = 32'h0; in_off = 2'd0;
    in_tag = 5'd1; in_valid = 1'b1;
    @(posedge clk); #1; in_tag = 5'd2; in_imm = 16'h0022;
    @(posedge clk); #1; in_tag = 5'd3; in_imm = 16'h0033;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || acc_count - base_acc != 2 || out_tag !== 5'd1) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b acc=%0d tag=%0d expected rdy=0 acc=2 tag=1",
               in_ready, acc_count - base_acc, out_tag);
    end
    out_ready = 1'b1;
    send(3'd0, 16'h0033, 32'h0, 2'd0, 5'd3);
    send(3'd0, 16'h0044, 32'h0, 2'd0, 5'd4);
    for (int i = 0; i < 20 && out_count - base_out < 4; i++) @(negedge clk);
    checks++;
    if (out_count - base_out != 4 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d outputs, %0d pending expected 4 outputs, 0 pending",
               out_count - base_out, sb.size());
    end
  endtask

  task automatic test_random();
    bit done = 0;
    do_reset();
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          int gap;
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
          end
          send(3'($urandom_range(0, 7)), 16'($urandom), $urandom,
               2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: got %0d pending v=%b expected 0 pending v=0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset_two();
    do_reset();
    out_ready = 1'b0;
    send(3'd5, 16'h0, 32'h12345678, 2'd1, 5'd9);
    send(3'd0, 16'h00AA, 32'h0, 2'd0, 5'd10);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL two_state: got rdy=%b cnt=%0d expected rdy=0 cnt=1", in_ready, err_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_two: got v=%b cnt=%0d rdy=%b expected v=0 cnt=0 rdy=0",
               out_valid, err_cnt, in_ready);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", in_ready);
    end
    send(3'd2, 16'h8001, 32'h0, 2'd0, 5'd3);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF8001 || out_tag !== 5'd3) begin
      errors++;
      $display("FAIL first_after_reset: got v=%b d=%h t=%0d expected v=1 d=ffff8001 t=3",
               out_valid, out_data, out_tag);
    end
  endtask

  initial begin
    test_reset();
    test_imm_modes();
    test_loads();
    test_misaligned();
    test_backpressure();
    test_random();
    test_reset_two();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion expected finish within 5ms");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
